// File: rtl/ct_result_buffer_if.sv
// Signal bundle between CT_module, the result buffer and its downstream consumer.
// The slave modport is the buffer's view; master is the driver/consumer side.
interface ct_result_buffer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
);
    logic              ct_en_result;
    logic [DATA_W-1:0] ct_result;
    logic              ct_done;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic [IDX_W-1:0]  buf_count;
    logic              overflow;
    logic              frame_done;
    logic              busy;

    modport master (
        output ct_en_result, ct_result, ct_done, out_ready,
        input  out_valid, out_data, out_index, out_last,
        input  buf_count, overflow, frame_done, busy
    );

    modport slave (
        input  ct_en_result, ct_result, ct_done, out_ready,
        output out_valid, out_data, out_index, out_last,
        output buf_count, overflow, frame_done, busy
    );
endinterface

// File: rtl/ct_result_buffer.sv
// Captures one frame of CT_module results (no backpressure upstream) and
// replays it in order over a valid/ready handshake to a possibly stalling consumer.
module ct_result_buffer #(
    parameter int DEPTH  = 36,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic            clk,
    input  logic            reset,
    ct_result_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] ONE_C   = IDX_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic              fdone_q, fdone_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [IDX_W-1:0]  nxt_ptr;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        vld_d    = vld_q;
        data_d   = data_q;
        idx_d    = idx_q;
        last_d   = last_q;
        fdone_d  = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = wr_ptr_q;
        mem_wd   = bus.ct_result;
        nxt_ptr  = rd_ptr_q + ONE_C;

        case (state_q)
            IDLE: begin
                if (bus.ct_en_result) begin
                    mem_we   = 1'b1;
                    mem_wa   = '0;
                    wr_ptr_d = ONE_C;
                    rd_ptr_d = '0;
                    cnt_d    = ONE_C;
                    ovf_d    = 1'b0;
                    state_d  = bus.ct_done ? DRAIN : CAPTURE;
                end else if (bus.ct_done) begin
                    fdone_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.ct_en_result) begin
                    if (cnt_q == DEPTH_C) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_C;
                        cnt_d    = cnt_q + ONE_C;
                    end
                end
                if (bus.ct_done) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.ct_en_result) ovf_d = 1'b1;
                // First DRAIN cycle only loads the output register; afterwards
                // each accepted element prefetches the next so transfers run back-to-back.
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                    idx_d  = rd_ptr_q;
                    last_d = (rd_ptr_q == cnt_q - ONE_C);
                end else if (bus.out_ready) begin
                    if (last_q) begin
                        vld_d    = 1'b0;
                        last_d   = 1'b0;
                        fdone_d  = 1'b1;
                        cnt_d    = '0;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        state_d  = IDLE;
                    end else begin
                        rd_ptr_d = nxt_ptr;
                        data_d   = mem_q[nxt_ptr];
                        idx_d    = nxt_ptr;
                        last_d   = (nxt_ptr == cnt_q - ONE_C);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            fdone_q  <= fdone_d;
        end
    end

    // Frame storage is never reset; only positions below cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign bus.out_valid  = vld_q;
    assign bus.out_data   = data_q;
    assign bus.out_index  = idx_q;
    assign bus.out_last   = last_q;
    assign bus.buf_count  = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.frame_done = fdone_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ct_result_buffer.sv
// Directed bench for ct_result_buffer: frames, backpressure, overflow, edge cases, reset.
module tb_ct_result_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ct_result_buffer_if #(.DATA_W(8), .IDX_W(6)) bus ();

    ct_result_buffer #(.DEPTH(36), .DATA_W(8), .IDX_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.ct_en_result = 1'b1;
        bus.ct_result    = v;
        step();
        bus.ct_en_result = 1'b0;
    endtask

    // End the frame (optionally with a final byte) and check the 2-cycle latency.
    task automatic finish(input bit with_byte, input logic [7:0] v);
        bus.ct_done      = 1'b1;
        bus.ct_en_result = with_byte;
        bus.ct_result    = v;
        step();
        bus.ct_done      = 1'b0;
        bus.ct_en_result = 1'b0;
        chk("lat_valid_c1", bus.out_valid, 0);
        chk("lat_busy", bus.busy, 1);
        step();
        chk("lat_valid_c2", bus.out_valid, 1);
    endtask

    task automatic drain(input logic [7:0] exp [$], input bit pat [$]);
        int   got = 0;
        int   cyc = 0;
        int   pi = 0;
        bit   stalled = 0;
        logic [7:0] hold_d = '0;
        logic [5:0] hold_i = '0;
        while (got < exp.size() && cyc < 200) begin
            bus.out_ready = (pi < pat.size()) ? pat[pi] : 1'b1;
            if (bus.out_valid) begin
                pi++;
                if (stalled) begin
                    chk("hold_data", bus.out_data, hold_d);
                    chk("hold_index", bus.out_index, hold_i);
                end
                if (bus.out_ready) begin
                    chk("data", bus.out_data, exp[got]);
                    chk("index", bus.out_index, got);
                    chk("last", bus.out_last, (got == exp.size() - 1));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = bus.out_data;
                    hold_i  = bus.out_index;
                end
            end
            step();
            cyc++;
        end
        chk("drain_timeout", (cyc < 200), 1);
        chk("end_valid", bus.out_valid, 0);
        chk("end_frame_done", bus.frame_done, 1);
        chk("end_busy", bus.busy, 0);
        chk("end_count", bus.buf_count, 0);
        step();
        chk("frame_done_pulse", bus.frame_done, 0);
    endtask

    initial begin
        logic [7:0] q [$];
        bit         none [$];
        bit         bp [$];

        bus.ct_en_result = 1'b0;
        bus.ct_result    = '0;
        bus.ct_done      = 1'b0;
        bus.out_ready    = 1'b1;
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.buf_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        reset = 1'b1;
        step();

        // Normal frame
        q = '{233, 123, 12, 3};
        foreach (q[i]) push(q[i]);
        chk("norm_count", bus.buf_count, 4);
        finish(0, 0);
        drain(q, none);

        // Backpressure
        bp = '{1, 0, 0, 1, 0, 1, 1};
        foreach (q[i]) push(q[i]);
        finish(0, 0);
        drain(q, bp);

        // Full buffer, no overflow
        q = {};
        for (int i = 0; i < 36; i++) begin
            q.push_back(8'(i));
            push(8'(i));
        end
        chk("full_count", bus.buf_count, 36);
        chk("full_overflow", bus.overflow, 0);
        finish(0, 0);
        drain(q, none);

        // Full buffer plus a dropped 37th byte
        for (int i = 0; i < 36; i++) push(8'(i));
        push(8'd99);
        chk("ovf_count", bus.buf_count, 36);
        chk("ovf_flag", bus.overflow, 1);
        finish(0, 0);
        drain(q, none);
        chk("ovf_sticky", bus.overflow, 1);

        // ct_done together with the last byte; first capture clears overflow
        push(8'd10);
        chk("ovf_cleared", bus.overflow, 0);
        push(8'd20);
        finish(1, 8'd55);
        q = '{10, 20, 55};
        drain(q, none);

        // Empty frame
        bus.ct_done = 1'b1;
        step();
        bus.ct_done = 1'b0;
        chk("empty_frame_done", bus.frame_done, 1);
        chk("empty_busy", bus.busy, 0);
        step();
        chk("empty_pulse_end", bus.frame_done, 0);
        for (int i = 0; i < 3; i++) begin
            chk("empty_no_valid", bus.out_valid, 0);
            step();
        end

        // Reset mid-drain after two transfers
        q = '{233, 123, 12, 3};
        foreach (q[i]) push(q[i]);
        finish(0, 0);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("pre_rst_index", bus.out_index, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_index", bus.out_index, 0);
        chk("arst_last", bus.out_last, 0);
        chk("arst_count", bus.buf_count, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_frame_done", bus.frame_done, 0);
        reset = 1'b1;
        step();
        push(8'd5);
        push(8'd2);
        finish(0, 0);
        q = '{5, 2};
        drain(q, none);

        // Late input during drain
        q = '{1, 2, 3};
        foreach (q[i]) push(q[i]);
        finish(0, 0);
        bus.out_ready    = 1'b0;
        bus.ct_en_result = 1'b1;
        bus.ct_result    = 8'd77;
        step();
        bus.ct_en_result = 1'b0;
        chk("late_overflow", bus.overflow, 1);
        chk("late_count", bus.buf_count, 3);
        drain(q, none);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
